// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver frame controller: state encoding,
// counter widths and the prescale value assumed out of reset.
package uart_rx_pkg;

    localparam int PRESCALE_W = 6;
    localparam int BIT_CNT_W  = 4;

    localparam logic [PRESCALE_W-1:0] PRESCALE_RST = 6'd8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        VALID  = 3'd5,
        BREAK  = 3'd6
    } rx_state_e;

    // States in which a bit is on the line and the oversample counter runs.
    function automatic logic is_counting(input rx_state_e st);
        return (st == START) || (st == DATA) || (st == PARITY) || (st == STOP);
    endfunction

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// Oversample (edge) and bit counters for the UART receiver. The edge counter
// wraps at the latched prescale value and each wrap advances the bit counter.
// A synchronous clear has priority over counting.
module uart_rx_edge_bit_counter
    import uart_rx_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_en,
    input  logic                  i_clr,
    input  logic [PRESCALE_W-1:0] i_prescale_q,
    output logic [PRESCALE_W-1:0] o_edge_cnt,
    output logic [BIT_CNT_W-1:0]  o_bit_cnt,
    output logic                  o_last,
    output logic                  o_pre_last
);

    logic [PRESCALE_W-1:0] r_edge_cnt;
    logic [BIT_CNT_W-1:0]  r_bit_cnt;
    logic                  w_last;
    logic                  w_pre_last;

    assign w_last     = (r_edge_cnt == (i_prescale_q - 6'd1));
    assign w_pre_last = (r_edge_cnt == (i_prescale_q - 6'd2));

    // Advance the edge counter each enabled cycle; wrap and bump the bit index on the last edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_edge_cnt <= 6'd0;
            r_bit_cnt  <= 4'd0;
        end else if (i_clr) begin
            r_edge_cnt <= 6'd0;
            r_bit_cnt  <= 4'd0;
        end else if (i_en) begin
            if (w_last) begin
                r_edge_cnt <= 6'd0;
                r_bit_cnt  <= r_bit_cnt + 4'd1;
            end else begin
                r_edge_cnt <= r_edge_cnt + 6'd1;
            end
        end
    end

    assign o_edge_cnt = r_edge_cnt;
    assign o_bit_cnt  = r_bit_cnt;
    assign o_last     = w_last;
    assign o_pre_last = w_pre_last;

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receiver frame controller. Walks start/data/parity/stop phases of an
// oversampled frame, drives the sampler/deserializer/checker enables and
// reports an accepted frame (data_valid) or a dropped one (frm_err).
// Optional line-break detection is compiled in with UART_RX_BREAK_DET_EN:
// an all-zero frame ending in a stop error raises break_det and parks in
// BREAK until the line returns high.
module uart_rx_fsm
    import uart_rx_pkg::*;
#(
    parameter int Data_width = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  sampled_bit,
    input  logic                  par_err,
    input  logic                  strt_glitch,
    input  logic                  stp_err,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [BIT_CNT_W-1:0]  bit_cnt,
    output logic                  dat_samp_en,
    output logic                  deser_en,
    output logic                  strt_chk_en,
    output logic                  par_chk_en,
    output logic                  stp_chk_en,
    output logic                  data_valid,
    output logic                  frm_err,
    output logic                  break_det
);

    localparam logic [BIT_CNT_W-1:0] LAST_DATA_BIT = BIT_CNT_W'(Data_width);

    rx_state_e             r_state;
    rx_state_e             w_next_state;
    logic [PRESCALE_W-1:0] r_prescale_q;
    logic                  w_last;
    logic                  w_pre_last;
    logic                  w_cnt_en;
    logic                  w_cnt_clr;
    logic                  w_frm_err;
    logic                  w_start_entry;

    logic                  r_dat_samp_en;
    logic                  r_deser_en;
    logic                  r_strt_chk_en;
    logic                  r_par_chk_en;
    logic                  r_stp_chk_en;
    logic                  r_data_valid;
    logic                  r_frm_err;

`ifdef UART_RX_BREAK_DET_EN
    logic                  r_zero_flag;
    logic                  w_break;
    logic                  r_break_det;
`else
    logic                  w_unused_sampled_bit;
`endif

    // Counters run while a bit is on the line; they restart whenever a
    // counting phase is entered from outside or left for a non-counting one.
    assign w_cnt_en      = is_counting(r_state);
    assign w_cnt_clr     = !is_counting(r_state) || !is_counting(w_next_state);
    assign w_start_entry = (w_next_state == START) && (r_state != START);

    uart_rx_edge_bit_counter u_counter (
        .i_clk        (CLK),
        .i_rst_n      (RST),
        .i_en         (w_cnt_en),
        .i_clr        (w_cnt_clr),
        .i_prescale_q (r_prescale_q),
        .o_edge_cnt   (edge_cnt),
        .o_bit_cnt    (bit_cnt),
        .o_last       (w_last),
        .o_pre_last   (w_pre_last)
    );

    // Next-state decode; checker results are only looked at on the last edge of their own phase.
    always_comb begin
        w_next_state = r_state;
        w_frm_err    = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
        w_break      = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (!RX_IN) w_next_state = START;
                else        w_next_state = IDLE;
            end
            START: begin
                if (w_last) w_next_state = strt_glitch ? IDLE : DATA;
                else        w_next_state = START;
            end
            DATA: begin
                if (w_last && (bit_cnt == LAST_DATA_BIT)) w_next_state = PAR_EN ? PARITY : STOP;
                else                                      w_next_state = DATA;
            end
            PARITY: begin
                if (w_last) begin
                    if (par_err) begin
                        w_next_state = IDLE;
                        w_frm_err    = 1'b1;
                    end else begin
                        w_next_state = STOP;
                    end
                end else begin
                    w_next_state = PARITY;
                end
            end
            STOP: begin
                if (w_last) begin
                    if (stp_err) begin
`ifdef UART_RX_BREAK_DET_EN
                        if (r_zero_flag) begin
                            w_next_state = BREAK;
                            w_break      = 1'b1;
                        end else begin
                            w_next_state = IDLE;
                            w_frm_err    = 1'b1;
                        end
`else
                        w_next_state = IDLE;
                        w_frm_err    = 1'b1;
`endif
                    end else begin
                        w_next_state = VALID;
                    end
                end else begin
                    w_next_state = STOP;
                end
            end
            VALID: begin
                if (!RX_IN) w_next_state = START;
                else        w_next_state = IDLE;
            end
            BREAK: begin
`ifdef UART_RX_BREAK_DET_EN
                if (RX_IN) w_next_state = IDLE;
                else       w_next_state = BREAK;
`else
                w_next_state = IDLE;
`endif
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // State register, prescale latch and registered Moore outputs aligned with the state they describe.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state       <= IDLE;
            r_prescale_q  <= PRESCALE_RST;
            r_dat_samp_en <= 1'b0;
            r_deser_en    <= 1'b0;
            r_strt_chk_en <= 1'b0;
            r_par_chk_en  <= 1'b0;
            r_stp_chk_en  <= 1'b0;
            r_data_valid  <= 1'b0;
            r_frm_err     <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_start_entry) begin
                r_prescale_q <= prescale;
            end
            r_dat_samp_en <= is_counting(w_next_state);
            r_strt_chk_en <= (w_next_state == START);
            r_par_chk_en  <= (w_next_state == PARITY);
            r_stp_chk_en  <= (w_next_state == STOP);
            r_data_valid  <= (w_next_state == VALID);
            r_frm_err     <= w_frm_err;
            // One edge early, so the strobe coincides with the last edge of each data bit.
            r_deser_en    <= (r_state == DATA) && w_pre_last;
        end
    end

`ifdef UART_RX_BREAK_DET_EN
    // Zero flag: armed on start entry, dropped once any data/parity bit samples high.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_zero_flag <= 1'b0;
            r_break_det <= 1'b0;
        end else begin
            if (w_start_entry) begin
                r_zero_flag <= 1'b1;
            end else if (((r_state == DATA) || (r_state == PARITY)) && w_last && sampled_bit) begin
                r_zero_flag <= 1'b0;
            end
            r_break_det <= w_break;
        end
    end

    assign break_det = r_break_det;
`else
    assign w_unused_sampled_bit = sampled_bit;
    assign break_det            = 1'b0;
`endif

    assign dat_samp_en = r_dat_samp_en;
    assign deser_en    = r_deser_en;
    assign strt_chk_en = r_strt_chk_en;
    assign par_chk_en  = r_par_chk_en;
    assign stp_chk_en  = r_stp_chk_en;
    assign data_valid  = r_data_valid;
    assign frm_err     = r_frm_err;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm. The bench plays both the line and an ideal
// sampler/checker set: sampled_bit follows RX_IN and the checker results are
// driven per scenario. A passive monitor records pulse counts and the cycle
// numbers of START entries, data_valid and frm_err for the tests to compare.
module tb_uart_rx_fsm;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       RX_IN = 1'b1;
    logic       PAR_EN = 1'b1;
    logic [5:0] prescale = 6'd8;
    logic       sampled_bit = 1'b1;
    logic       par_err = 1'b0;
    logic       strt_glitch = 1'b0;
    logic       stp_err = 1'b0;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en;
    logic       data_valid, frm_err, break_det;

    int n_tests = 0;
    int n_fail  = 0;
    int ps_tb   = 8;

    int         cyc = 0;
    int         n_start, n_deser, n_dv, n_frm, n_brk, n_both;
    int         st_t [4];
    int         dv_t [4];
    int         frm_t[4];
    logic [7:0] rx_byte;
    logic       prev_strt = 1'b0;

    uart_rx_fsm #(.Data_width(8)) dut (
        .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .prescale(prescale),
        .sampled_bit(sampled_bit), .par_err(par_err), .strt_glitch(strt_glitch), .stp_err(stp_err),
        .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .dat_samp_en(dat_samp_en), .deser_en(deser_en),
        .strt_chk_en(strt_chk_en), .par_chk_en(par_chk_en), .stp_chk_en(stp_chk_en),
        .data_valid(data_valid), .frm_err(frm_err), .break_det(break_det)
    );

    always #5 CLK = ~CLK;

    // Passive monitor, sampling 1 time unit after each rising edge.
    always @(posedge CLK) begin
        #1;
        cyc = cyc + 1;
        if (strt_chk_en && !prev_strt) begin
            if (n_start < 4) st_t[n_start] = cyc;
            n_start = n_start + 1;
        end
        prev_strt = strt_chk_en;
        if (deser_en) begin
            n_deser = n_deser + 1;
            rx_byte = {sampled_bit, rx_byte[7:1]};
        end
        if (data_valid) begin
            if (n_dv < 4) dv_t[n_dv] = cyc;
            n_dv = n_dv + 1;
        end
        if (frm_err) begin
            if (n_frm < 4) frm_t[n_frm] = cyc;
            n_frm = n_frm + 1;
        end
        if (break_det) n_brk = n_brk + 1;
        if (data_valid && frm_err) n_both = n_both + 1;
    end

    task automatic clr_mon();
        n_start = 0; n_deser = 0; n_dv = 0; n_frm = 0; n_brk = 0; n_both = 0;
        rx_byte = 8'h00;
        for (int i = 0; i < 4; i++) begin
            st_t[i] = 0; dv_t[i] = 0; frm_t[i] = 0;
        end
    endtask

    // Hold the line (and ideal sampler) at b for n clock periods, negedge aligned.
    task automatic drive_bit(input logic b, input int n);
        RX_IN = b;
        sampled_bit = b;
        repeat (n) @(negedge CLK);
    endtask

    task automatic send_frame(input logic [7:0] d, input int start_len, input logic with_par,
                              input logic p, input logic stp);
        drive_bit(1'b0, start_len);
        for (int i = 0; i < 8; i++) drive_bit(d[i], ps_tb);
        if (with_par) drive_bit(p, ps_tb);
        drive_bit(stp, ps_tb);
        RX_IN = 1'b1;
        sampled_bit = 1'b1;
    endtask

    task automatic test_reset();
        logic [22:0] outs;
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        outs = {edge_cnt, bit_cnt, dat_samp_en, deser_en, strt_chk_en, par_chk_en,
                stp_chk_en, data_valid, frm_err, break_det};
        n_tests++;
        if (outs !== 23'd0) begin
            n_fail++; $display("FAIL reset_outputs: got %h want 0", outs);
        end
        RST = 1'b1;
        drive_bit(1'b1, 4);
        outs = {edge_cnt, bit_cnt, dat_samp_en, deser_en, strt_chk_en, par_chk_en,
                stp_chk_en, data_valid, frm_err, break_det};
        n_tests++;
        if (outs !== 23'd0) begin
            n_fail++; $display("FAIL idle_after_reset: got %h want 0", outs);
        end
    endtask

    task automatic test_frame();
        @(negedge CLK);
        clr_mon();
        send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b1);
        drive_bit(1'b1, 6);
        n_tests++;
        if (n_deser !== 8) begin n_fail++; $display("FAIL frame_deser_cnt: got %0d want 8", n_deser); end
        n_tests++;
        if (rx_byte !== 8'hA5) begin n_fail++; $display("FAIL frame_byte: got %h want a5", rx_byte); end
        n_tests++;
        if (n_dv !== 1) begin n_fail++; $display("FAIL frame_dv_cnt: got %0d want 1", n_dv); end
        n_tests++;
        if (dv_t[0] - st_t[0] !== 88) begin
            n_fail++; $display("FAIL frame_latency: got %0d want 88", dv_t[0] - st_t[0]);
        end
        n_tests++;
        if (n_frm !== 0 || n_both !== 0) begin
            n_fail++; $display("FAIL frame_no_err: got frm=%0d both=%0d want 0 0", n_frm, n_both);
        end
    endtask

    task automatic test_glitch();
        @(negedge CLK);
        clr_mon();
        strt_glitch = 1'b1;
        drive_bit(1'b0, 2);
        drive_bit(1'b1, 12);
        strt_glitch = 1'b0;
        n_tests++;
        if (n_start !== 1) begin n_fail++; $display("FAIL glitch_start_seen: got %0d want 1", n_start); end
        n_tests++;
        if (n_deser !== 0 || n_dv !== 0 || n_frm !== 0) begin
            n_fail++; $display("FAIL glitch_silent: got deser=%0d dv=%0d frm=%0d want 0 0 0", n_deser, n_dv, n_frm);
        end
        n_tests++;
        if (dat_samp_en !== 1'b0 || edge_cnt !== 6'd0) begin
            n_fail++; $display("FAIL glitch_idle: got samp=%b edge=%0d want 0 0", dat_samp_en, edge_cnt);
        end
    endtask

    task automatic test_par_err();
        @(negedge CLK);
        clr_mon();
        par_err = 1'b1;
        send_frame(8'h5A, 8, 1'b1, 1'b1, 1'b1);
        drive_bit(1'b1, 6);
        par_err = 1'b0;
        n_tests++;
        if (n_frm !== 1) begin n_fail++; $display("FAIL parerr_frm_cnt: got %0d want 1", n_frm); end
        n_tests++;
        if (frm_t[0] - st_t[0] !== 80) begin
            n_fail++; $display("FAIL parerr_timing: got %0d want 80", frm_t[0] - st_t[0]);
        end
        n_tests++;
        if (n_dv !== 0) begin n_fail++; $display("FAIL parerr_no_dv: got %0d want 0", n_dv); end
        n_tests++;
        if (dat_samp_en !== 1'b0) begin n_fail++; $display("FAIL parerr_idle: got %b want 0", dat_samp_en); end
    endtask

    task automatic test_back_to_back();
        @(negedge CLK);
        clr_mon();
        send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b1);
        // The VALID cycle consumes one sample, so the second start bit is one cycle longer.
        send_frame(8'h3C, 9, 1'b1, 1'b0, 1'b1);
        drive_bit(1'b1, 6);
        n_tests++;
        if (n_dv !== 2) begin n_fail++; $display("FAIL b2b_dv_cnt: got %0d want 2", n_dv); end
        n_tests++;
        if (st_t[1] !== dv_t[0] + 1) begin
            n_fail++; $display("FAIL b2b_restart: got %0d want %0d", st_t[1], dv_t[0] + 1);
        end
        n_tests++;
        if (dv_t[1] - st_t[1] !== 88) begin
            n_fail++; $display("FAIL b2b_latency2: got %0d want 88", dv_t[1] - st_t[1]);
        end
        n_tests++;
        if (n_deser !== 16 || rx_byte !== 8'h3C) begin
            n_fail++; $display("FAIL b2b_data: got n=%0d byte=%h want 16 3c", n_deser, rx_byte);
        end
    endtask

    task automatic test_prescale4_nopar();
        @(negedge CLK);
        clr_mon();
        ps_tb = 4; prescale = 6'd4; PAR_EN = 1'b0; par_err = 1'b1;
        send_frame(8'h81, 4, 1'b0, 1'b0, 1'b1);
        drive_bit(1'b1, 6);
        ps_tb = 8; prescale = 6'd8; PAR_EN = 1'b1; par_err = 1'b0;
        n_tests++;
        if (n_dv !== 1 || dv_t[0] - st_t[0] !== 40) begin
            n_fail++; $display("FAIL ps4_latency: got dv=%0d lat=%0d want 1 40", n_dv, dv_t[0] - st_t[0]);
        end
        n_tests++;
        if (rx_byte !== 8'h81 || n_deser !== 8) begin
            n_fail++; $display("FAIL ps4_data: got byte=%h n=%0d want 81 8", rx_byte, n_deser);
        end
        n_tests++;
        if (n_frm !== 0) begin n_fail++; $display("FAIL ps4_parerr_ignored: got %0d want 0", n_frm); end
    endtask

    task automatic test_reset_mid();
        logic        hit = 1'b0;
        logic [22:0] outs;
        @(negedge CLK);
        clr_mon();
        RX_IN = 1'b0; sampled_bit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(posedge CLK); #2;
            if (bit_cnt == 4'd4 && edge_cnt == 6'd3) hit = 1'b1;
        end
        n_tests++;
        if (!hit) begin n_fail++; $display("FAIL midrst_reach: got timeout want bit4 edge3"); end
        RST = 1'b0;
        #1;
        outs = {edge_cnt, bit_cnt, dat_samp_en, deser_en, strt_chk_en, par_chk_en,
                stp_chk_en, data_valid, frm_err, break_det};
        n_tests++;
        if (outs !== 23'd0) begin n_fail++; $display("FAIL midrst_async: got %h want 0", outs); end
        RX_IN = 1'b1; sampled_bit = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        drive_bit(1'b1, 5);
        n_tests++;
        if (dat_samp_en !== 1'b0 || bit_cnt !== 4'd0 || edge_cnt !== 6'd0 || n_dv !== 0 || n_frm !== 0) begin
            n_fail++; $display("FAIL midrst_idle: got samp=%b bit=%0d edge=%0d dv=%0d frm=%0d want all 0",
                               dat_samp_en, bit_cnt, edge_cnt, n_dv, n_frm);
        end
    endtask

    task automatic test_break();
        @(negedge CLK);
        clr_mon();
        stp_err = 1'b1;
        drive_bit(1'b0, 160);
`ifdef UART_RX_BREAK_DET_EN
        n_tests++;
        if (n_brk !== 1 || n_frm !== 0) begin
            n_fail++; $display("FAIL break_pulse: got brk=%0d frm=%0d want 1 0", n_brk, n_frm);
        end
        n_tests++;
        if (n_start !== 1 || dat_samp_en !== 1'b0) begin
            n_fail++; $display("FAIL break_hold: got starts=%0d samp=%b want 1 0", n_start, dat_samp_en);
        end
        stp_err = 1'b0;
        drive_bit(1'b1, 3);
        drive_bit(1'b0, 2);
        n_tests++;
        if (n_start !== 2) begin n_fail++; $display("FAIL break_release: got starts=%0d want 2", n_start); end
`else
        n_tests++;
        if (n_frm !== 1 || n_brk !== 0) begin
            n_fail++; $display("FAIL break_as_frm: got frm=%0d brk=%0d want 1 0", n_frm, n_brk);
        end
        n_tests++;
        if (frm_t[0] - st_t[0] !== 88) begin
            n_fail++; $display("FAIL break_frm_timing: got %0d want 88", frm_t[0] - st_t[0]);
        end
        n_tests++;
        if (n_start !== 2 || st_t[1] !== frm_t[0] + 1) begin
            n_fail++; $display("FAIL break_restart: got starts=%0d at %0d want 2 at %0d",
                               n_start, st_t[1], frm_t[0] + 1);
        end
`endif
        stp_err = 1'b0;
        RST = 1'b0;
        drive_bit(1'b1, 2);
        RST = 1'b1;
        drive_bit(1'b1, 3);
    endtask

    initial begin
        clr_mon();
        test_reset();
        test_frame();
        test_glitch();
        test_par_err();
        test_back_to_back();
        test_prescale4_nopar();
        test_reset_mid();
        test_break();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
